// File: rtl/ref_clock_gen.sv
// ref_clock_gen: programmable NCO square-wave reference with wrap-aligned config.
// Define REFGEN_JITTER_EN to dither the phase step from a 16-bit LFSR.
module ref_clock_gen #(
  parameter int ACC_WIDTH = 16,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_FREQ = 'h199A,
  parameter int CNT_WIDTH = 8,
  parameter int JITTER_BITS = 4
) (
  input  logic                 oscInput,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ACC_WIDTH-1:0] freqWord,
  input  logic [ACC_WIDTH-1:0] phaseStep,
  input  logic                 cfgValid,
  output logic                 cfgReady,
  output logic                 refOut,
  output logic                 risePulse,
  output logic [CNT_WIDTH-1:0] edgeCount
);
  localparam logic [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) << (ACC_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, PEND} stateE;

  stateE                state, stateNext;
  logic [ACC_WIDTH-1:0] acc, accNext;
  logic [ACC_WIDTH-1:0] inc, incNext;
  logic [ACC_WIDTH-1:0] shFreq, shFreqNext;
  logic [ACC_WIDTH-1:0] shStep, shStepNext;
  logic                 cfgReadyNext;
  logic [ACC_WIDTH-1:0] step;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] freqClamped;
  logic                 fire;
  logic                 wrap;
  logic                 rise;

  assign fire        = cfgValid & cfgReady;
  assign freqClamped = (freqWord > HALF) ? HALF : freqWord;
  assign sum         = {1'b0, acc} + {1'b0, step};
  assign wrap        = sum[ACC_WIDTH];
  assign refOut      = acc[ACC_WIDTH-1];
  assign rise        = ~acc[ACC_WIDTH-1] & accNext[ACC_WIDTH-1];

`ifdef REFGEN_JITTER_EN
  localparam logic [ACC_WIDTH-1:0] BIAS = ACC_WIDTH'(1) << (JITTER_BITS - 1);
  logic [15:0]          lfsr;
  logic [ACC_WIDTH-1:0] dither;

  always_ff @(posedge oscInput) begin
    if (!reset)
      lfsr <= 16'hACE1;
    else if (state != IDLE)
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Dither is suppressed at the frozen and fclk/2 extremes.
  assign dither = (inc == '0 || inc == HALF) ? '0 :
                  ACC_WIDTH'(lfsr[JITTER_BITS-1:0]) - BIAS;
  assign step = inc + dither;
`else
  logic unusedJitter;
  assign unusedJitter = ^JITTER_BITS;
  assign step = inc;
`endif

  always_ff @(posedge oscInput) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      inc       <= DEFAULT_FREQ;
      shFreq    <= '0;
      shStep    <= '0;
      cfgReady  <= 1'b1;
      risePulse <= 1'b0;
      edgeCount <= '0;
    end else begin
      state     <= stateNext;
      acc       <= accNext;
      inc       <= incNext;
      shFreq    <= shFreqNext;
      shStep    <= shStepNext;
      cfgReady  <= cfgReadyNext;
      risePulse <= rise;
      edgeCount <= edgeCount + CNT_WIDTH'(rise);
    end
  end

  always_comb begin
    stateNext    = state;
    accNext      = acc;
    incNext      = inc;
    shFreqNext   = shFreq;
    shStepNext   = shStep;
    cfgReadyNext = cfgReady;
    unique case (state)
      IDLE: begin
        accNext = '0;
        if (fire)
          incNext = freqClamped;
        if (enable)
          stateNext = RUN;
      end
      RUN: begin
        if (!enable) begin
          accNext   = '0;
          stateNext = IDLE;
          if (fire)
            incNext = freqClamped;
        end else begin
          accNext = sum[ACC_WIDTH-1:0];
          if (fire) begin
            shFreqNext   = freqClamped;
            shStepNext   = phaseStep;
            cfgReadyNext = 1'b0;
            stateNext    = PEND;
          end
        end
      end
      PEND: begin
        if (!enable) begin
          accNext      = '0;
          incNext      = shFreq;
          cfgReadyNext = 1'b1;
          stateNext    = IDLE;
        end else if (wrap) begin
          // The wrap cycle still steps by the old inc; the new one starts after.
          accNext      = sum[ACC_WIDTH-1:0] + shStep;
          incNext      = shFreq;
          cfgReadyNext = 1'b1;
          stateNext    = RUN;
        end else begin
          accNext = sum[ACC_WIDTH-1:0];
        end
      end
      default: begin
        accNext   = '0;
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ref_clock_gen.sv
// tb_ref_clock_gen: scoreboarded bench for ref_clock_gen (default build).
// Directed scenarios followed by randomized enable/config/reset traffic.
module tb_ref_clock_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] fw;
  logic [15:0] ps;
  logic        cv;
  logic        cfgReady;
  logic        refOut;
  logic        risePulse;
  logic [7:0]  edgeCount;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int cyc;
    bit refV;
    bit rdy;
    bit rise;
    int cnt;
  } expT;

  expT expQ[$];

  // Behavioural reference: phase as an integer in [0, 65536).
  int mPhase, mInc, mPFreq, mPStep, mEdges, mCyc;
  bit mRunning, mPending, mReady, mFired;

  ref_clock_gen dut (
    .oscInput (clk),
    .reset    (rst),
    .enable   (en),
    .freqWord (fw),
    .phaseStep(ps),
    .cfgValid (cv),
    .cfgReady (cfgReady),
    .refOut   (refOut),
    .risePulse(risePulse),
    .edgeCount(edgeCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    int  total;
    int  clampF;
    bit  prevHigh, nowHigh;
    expT e;
    mCyc++;
    mFired   = cv && mReady;
    clampF   = (int'(fw) > 32768) ? 32768 : int'(fw);
    prevHigh = mPhase >= 32768;
    if (!rst) begin
      mPhase = 0; mInc = 16'h199A; mPFreq = 0; mPStep = 0;
      mEdges = 0; mRunning = 0; mPending = 0; mReady = 1;
      prevHigh = 1;
    end else if (!mRunning) begin
      mPhase = 0;
      if (mFired) mInc = clampF;
      mRunning = en;
    end else if (!en) begin
      mPhase = 0;
      mRunning = 0;
      if (mPending) begin
        mInc = mPFreq; mPending = 0; mReady = 1;
      end else if (mFired) begin
        mInc = clampF;
      end
    end else begin
      total = mPhase + mInc;
      if (mPending && total >= 65536) begin
        mPhase = (total + mPStep) % 65536;
        mInc = mPFreq; mPending = 0; mReady = 1;
      end else begin
        mPhase = total % 65536;
        if (mFired) begin
          mPending = 1; mPFreq = clampF; mPStep = int'(ps); mReady = 0;
        end
      end
    end
    nowHigh = mPhase >= 32768;
    e.rise = rst && !prevHigh && nowHigh;
    if (e.rise) mEdges = (mEdges + 1) % 256;
    e.cyc  = mCyc;
    e.refV = nowHigh;
    e.rdy  = mReady;
    e.cnt  = mEdges;
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    modelStep();
  endtask

  task automatic offer(input logic [15:0] f, input logic [15:0] p);
    bit done = 0;
    fw = f; ps = p; cv = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      done = mFired;
    end
    cv = 1'b0;
    chk("offerAccepted", 32'(done), 32'd1);
  endtask

  task automatic checkPeriod(input string name, input int expP);
    int first = -1;
    int gap = -1;
    for (int i = 0; i < 400 && gap < 0; i++) begin
      tick();
      if (risePulse === 1'b1) begin
        if (first < 0) first = i;
        else gap = i - first;
      end
    end
    chk(name, 32'(gap), 32'(expP));
  endtask

  always @(negedge clk) begin
    expT e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk($sformatf("refOut@%0d", e.cyc), 32'(refOut), 32'(e.refV));
      chk($sformatf("risePulse@%0d", e.cyc), 32'(risePulse), 32'(e.rise));
      chk($sformatf("cfgReady@%0d", e.cyc), 32'(cfgReady), 32'(e.rdy));
      chk($sformatf("edgeCount@%0d", e.cyc), 32'(edgeCount), 32'(e.cnt));
    end
  end

  initial begin
    logic [15:0] freqTab [8];
    freqTab = '{16'h1000, 16'h2000, 16'h0800, 16'h8000,
                16'hC000, 16'hFFFF, 16'h0000, 16'h4000};
    mCyc = 0; mReady = 1; mPhase = 0;
    rst = 1'b0; en = 1'b0; fw = '0; ps = '0; cv = 1'b0;

    // Reset, then 0x1000 gives a 16-cycle period.
    repeat (5) tick();
    rst = 1'b1;
    offer(16'h1000, 16'h0000);
    en = 1'b1;
    checkPeriod("period1000", 16);

    // Over-range word clamps to fclk/2.
    en = 1'b0; tick();
    offer(16'hC000, 16'h0000);
    en = 1'b1;
    checkPeriod("periodClamp", 2);

    // Mid-period change to 0x2000 lands at the wrap.
    en = 1'b0; tick();
    offer(16'h1000, 16'h0000);
    en = 1'b1;
    repeat (20) tick();
    offer(16'h2000, 16'h0000);
    chk("readyLowPending", 32'(cfgReady), 32'd0);
    repeat (30) tick();
    checkPeriod("period2000", 8);

    // Same freq with a half-cycle phase step.
    en = 1'b0; tick();
    offer(16'h1000, 16'h0000);
    en = 1'b1;
    repeat (21) tick();
    offer(16'h1000, 16'h8000);
    repeat (40) tick();

    // Disable while high, then re-enable.
    for (int i = 0; i < 40 && mPhase < 32768; i++) tick();
    en = 1'b0;
    tick();
    chk("refOutDisabled", 32'(refOut), 32'd0);
    en = 1'b1;
    repeat (30) tick();

    // Reset overrides a pending config.
    offer(16'h2000, 16'h0000);
    rst = 1'b0;
    tick();
    chk("readyAfterReset", 32'(cfgReady), 32'd1);
    chk("countAfterReset", 32'(edgeCount), 32'd0);
    rst = 1'b1;
    en = 1'b1;
    checkPeriod("periodDefault", 10);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 799) != 0);
      if ($urandom_range(0, 149) == 0) en = ~en;
      cv = ($urandom_range(0, 7) == 0);
      fw = ($urandom_range(0, 3) == 0) ? 16'($urandom) : freqTab[$urandom_range(0, 7)];
      ps = 16'($urandom);
      tick();
    end
    cv = 1'b0;
    tick();
    @(negedge clk);
    #1;
    chk("queueDrained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
